// File: rtl/pack_pk_stream_if.sv
`default_nettype none
// ============================================================================
// pack_pk_stream_if: coefficient-in / byte-out stream bundle.  Rev 1.0
// ============================================================================
interface pack_pk_stream_if;
  logic        coef_valid;
  logic        coef_ready;
  logic [31:0] coef_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;

  // master = packer side, slave = coefficient source / byte sink side
  modport master (
    input  coef_valid, coef_data, byte_ready,
    output coef_ready, byte_valid, byte_data, byte_last
  );
  modport slave (
    output coef_valid, coef_data, byte_ready,
    input  coef_ready, byte_valid, byte_data, byte_last
  );
endinterface
`default_nettype wire

// File: rtl/pack_pk_stream.sv
`default_nettype none
// ============================================================================
// pack_pk_stream: streams rho, then K bit-packed t1 polynomials, as pk bytes.
// Rev 1.0
// ============================================================================
module pack_pk_stream #(
  parameter int K          = 6,
  parameter int COEFF_BITS = 10,
  parameter int SEED_BYTES = 32
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    start,
  input  wire logic [8*SEED_BYTES-1:0] rho,
  pack_pk_stream_if.master             strm,
  output logic                         busy,
  output logic                         done,
  output logic                         range_err
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEED = 2'd1;
  localparam logic [1:0] ST_COEF = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int N_COEF = 256 * K;
  localparam int CCW    = $clog2(N_COEF + 1);
  localparam int SCW    = $clog2(SEED_BYTES + 1);
  localparam int AW     = COEFF_BITS + 7;
  localparam int BW     = $clog2(COEFF_BITS + 8);

  logic [1:0]              state, state_nxt;
  logic [8*SEED_BYTES-1:0] rho_sr;
  logic [SCW-1:0]          seed_cnt;
  logic [CCW-1:0]          coef_cnt;
  logic [AW-1:0]           acc, acc_sh, acc_nxt, coef_ins;
  logic [BW-1:0]           bits, bits_sh, bits_nxt;
  logic                    start_acc, byte_hs, coef_hs, seed_last, coef_over;

  assign start_acc = start && (state == ST_IDLE);
  assign byte_hs   = strm.byte_valid && strm.byte_ready;
  assign coef_hs   = strm.coef_valid && strm.coef_ready;
  assign seed_last = (seed_cnt == SCW'(SEED_BYTES - 1));

  generate
    if (COEFF_BITS < 32) begin : g_range_chk
      assign coef_over = |strm.coef_data[31:COEFF_BITS];
    end else begin : g_no_range_chk
      assign coef_over = 1'b0;
    end
  endgenerate

  // Drain before insert, so a same-cycle coefficient lands at (bits - 8).
  always_comb begin
    acc_sh  = acc;
    bits_sh = bits;
    if ((state == ST_COEF) && byte_hs) begin
      acc_sh  = acc >> 8;
      bits_sh = bits - BW'(8);
    end
    coef_ins = AW'(strm.coef_data[COEFF_BITS-1:0]) << bits_sh;
    acc_nxt  = coef_hs ? (acc_sh | coef_ins) : acc_sh;
    bits_nxt = coef_hs ? (bits_sh + BW'(COEFF_BITS)) : bits_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SEED;
      ST_SEED: if (byte_hs && seed_last) state_nxt = ST_COEF;
      ST_COEF: if (byte_hs && strm.byte_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    strm.coef_ready = 1'b0;
    strm.byte_valid = 1'b0;
    strm.byte_data  = 8'h00;
    strm.byte_last  = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      ST_SEED: begin
        busy            = 1'b1;
        strm.byte_valid = 1'b1;
        strm.byte_data  = rho_sr[7:0];
      end
      ST_COEF: begin
        busy            = 1'b1;
        strm.coef_ready = (coef_cnt < CCW'(N_COEF)) && (bits < BW'(8));
        strm.byte_valid = (bits >= BW'(8));
        strm.byte_data  = acc[7:0];
        strm.byte_last  = (coef_cnt == CCW'(N_COEF)) && (bits == BW'(8));
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rho_sr    <= '0;
      seed_cnt  <= '0;
      coef_cnt  <= '0;
      acc       <= '0;
      bits      <= '0;
      range_err <= 1'b0;
    end else if (start_acc) begin
      rho_sr    <= rho;
      seed_cnt  <= '0;
      coef_cnt  <= '0;
      acc       <= '0;
      bits      <= '0;
      range_err <= 1'b0;
    end else begin
      if ((state == ST_SEED) && byte_hs) begin
        rho_sr   <= rho_sr >> 8;
        seed_cnt <= seed_cnt + 1'b1;
      end
      if (state == ST_COEF) begin
        acc  <= acc_nxt;
        bits <= bits_nxt;
      end
      if (coef_hs) begin
        coef_cnt <= coef_cnt + 1'b1;
        if (coef_over) range_err <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pack_pk_stream.sv
`default_nettype none
// tb_pack_pk_stream: queue scoreboard for the K=6 packer (directed + random runs)
// and free-running K=4 / K=8 sweep lanes checked against a bit-level packer model.
module tb_pack_pk_stream;
  localparam int CB    = 10;
  localparam int K6    = 6;
  localparam int NB6   = 32 + 32 * K6 * CB;
  localparam int LIMIT = 20000;
  localparam logic [255:0] SW_RHO = {8{32'h5A3C_96E1}};

  logic         clk = 1'b0;
  logic         rst_n, rst_sw_n, start;
  logic [255:0] rho;
  logic         busy, done, range_err;
  int           total = 0;
  int           bad = 0;
  int           popped = 0;
  logic [1:0]   sw_fin;
  logic [31:0]  rnd_coef [0:2047];
  logic [8:0]   sb [$];
  bit           prev_last_hs = 1'b0;

  pack_pk_stream_if pk();

  pack_pk_stream #(.K(K6), .COEFF_BITS(CB), .SEED_BYTES(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rho(rho), .strm(pk),
    .busy(busy), .done(done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cval(input int mode, input int i);
    case (mode)
      0:       cval = (i == 0) ? 32'h3FF : (i == 1) ? 32'h1 : 32'h0;
      1:       cval = (i == 0) ? 32'h400 : 32'h0;
      2:       cval = 32'(i % 1024);
      default: cval = rnd_coef[i];
    endcase
  endfunction

  // Byte j of the pk: seed bytes, then the packed bit string, LSB first.
  function automatic logic [7:0] exp_byte(input int j, input int mode, input logic [255:0] r);
    logic [7:0]  b;
    logic [31:0] c;
    int          bp;
    if (j < 32) return r[8*j +: 8];
    b = 8'h00;
    for (int t = 0; t < 8; t++) begin
      bp   = (j - 32) * 8 + t;
      c    = cval(mode, bp / CB);
      b[t] = c[bp % CB];
    end
    return b;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_coef_ready"}, 32'(pk.coef_ready), 32'd0);
    chk({tag, "_byte_valid"}, 32'(pk.byte_valid), 32'd0);
    chk({tag, "_byte_data"},  32'(pk.byte_data),  32'd0);
    chk({tag, "_byte_last"},  32'(pk.byte_last),  32'd0);
    chk({tag, "_busy"},       32'(busy),          32'd0);
    chk({tag, "_done"},       32'(done),          32'd0);
    chk({tag, "_range_err"},  32'(range_err),     32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last_hs = 1'b0;
    end else begin
      chk("done_timing", 32'(done), 32'(prev_last_hs));
      prev_last_hs = 1'b0;
      if (pk.byte_valid) begin
        if (sb.size() == 0) begin
          chk("byte_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          chk("byte_data", 32'(pk.byte_data), 32'(sb[0][7:0]));
          if (pk.byte_ready) begin
            chk("byte_last", 32'(pk.byte_last), 32'(sb[0][8]));
            prev_last_hs = sb[0][8];
            void'(sb.pop_front());
            popped++;
          end
        end
      end
    end
  end

  task automatic run_stream(input int mode, input bit rnd, input int abort_at, input int poke_at);
    logic [255:0] r;
    bit           exp_err, hs;
    int           ci, cyc;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    if (mode == 0) for (int i = 0; i < 32; i++) r[8*i +: 8] = 8'(i);
    exp_err = 1'b0;
    for (int i = 0; i < 256 * K6; i++) if ((cval(mode, i) >> CB) != 0) exp_err = 1'b1;
    sb.delete();
    popped = 0;
    for (int j = 0; j < NB6; j++) sb.push_back({(j == NB6 - 1), exp_byte(j, mode, r)});

    @(posedge clk); #1;
    rho           = r;
    start         = 1'b1;
    pk.coef_valid = 1'b0;
    pk.byte_ready = !rnd || ($urandom_range(0, 3) != 0);
    @(posedge clk); #1;
    start = 1'b0;
    rho   = ~r;
    @(negedge clk);
    chk("start_valid",   32'(pk.byte_valid), 32'd1);
    chk("start_byte0",   32'(pk.byte_data),  32'(r[7:0]));
    chk("start_busy",    32'(busy),          32'd1);
    chk("start_err_clr", 32'(range_err),     32'd0);

    ci  = 0;
    cyc = 0;
    forever begin
      hs = pk.coef_valid && pk.coef_ready;
      if (done) break;
      if ((abort_at >= 0) && (popped >= abort_at)) break;
      if (cyc >= LIMIT) begin
        chk("stream_timeout", 32'(done), 32'd1);
        break;
      end
      @(posedge clk); #1;
      if (hs) ci++;
      pk.coef_valid = (ci < 256 * K6) && (!rnd || ($urandom_range(0, 3) != 0));
      pk.coef_data  = (ci < 256 * K6) ? cval(mode, ci) : 32'h0;
      pk.byte_ready = !rnd || ($urandom_range(0, 3) != 0);
      start         = (cyc == poke_at);
      @(negedge clk);
      cyc++;
    end

    if (abort_at >= 0) begin
      @(posedge clk); #1;
      rst_n         = 1'b0;
      pk.coef_valid = 1'b0;
      pk.byte_ready = 1'b1;
      #1;
      check_reset("abort");
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      chk("end_busy",      32'(busy),      32'd0);
      chk("end_queue",     32'(sb.size()), 32'd0);
      chk("end_bytes",     32'(popped),    32'(NB6));
      chk("end_range_err", 32'(range_err), 32'(exp_err));
      @(posedge clk); #1;
      pk.coef_valid = 1'b0;
      pk.byte_ready = 1'b1;
      start         = 1'b0;
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int KS = (gi == 0) ? 4 : 8;
      localparam int NS = 32 + 32 * KS * CB;
      pack_pk_stream_if sbus();
      logic       st, s_busy, s_done, s_err;
      logic [7:0] sq [$];
      int         got = 0;

      pack_pk_stream #(.K(KS), .COEFF_BITS(CB), .SEED_BYTES(32)) u_dut (
        .clk(clk), .rst_n(rst_sw_n), .start(st), .rho(SW_RHO), .strm(sbus),
        .busy(s_busy), .done(s_done), .range_err(s_err)
      );

      always @(negedge clk) begin
        if (rst_sw_n && sbus.byte_valid && sbus.byte_ready) begin
          if (sq.size() == 0) begin
            chk($sformatf("sweep_k%0d_extra", KS), 32'(sq.size()), 32'd1);
          end else begin
            chk($sformatf("sweep_k%0d_byte%0d", KS, got), 32'(sbus.byte_data), 32'(sq.pop_front()));
            chk($sformatf("sweep_k%0d_last%0d", KS, got), 32'(sbus.byte_last), 32'(got == NS - 1));
          end
          got++;
        end
      end

      initial begin : lane
        int ci;
        bit hs;
        st              = 1'b0;
        sbus.coef_valid = 1'b0;
        sbus.coef_data  = 32'h0;
        sbus.byte_ready = 1'b1;
        ci              = 0;
        for (int j = 0; j < NS; j++) sq.push_back(exp_byte(j, 2, SW_RHO));
        wait (rst_sw_n === 1'b1);
        @(posedge clk); #1;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
          @(negedge clk);
          if (s_done) break;
          hs = sbus.coef_valid && sbus.coef_ready;
          @(posedge clk); #1;
          if (hs) ci++;
          sbus.coef_valid = (ci < 256 * KS);
          sbus.coef_data  = 32'(ci % 1024);
        end
        chk($sformatf("sweep_k%0d_done", KS),  32'(s_done), 32'd1);
        chk($sformatf("sweep_k%0d_count", KS), 32'(got),    32'(NS));
        chk($sformatf("sweep_k%0d_err", KS),   32'(s_err),  32'd0);
        sw_fin[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    rst_n         = 1'b0;
    rst_sw_n      = 1'b0;
    start         = 1'b0;
    rho           = '0;
    sw_fin        = 2'b00;
    pk.coef_valid = 1'b0;
    pk.coef_data  = 32'h0;
    pk.byte_ready = 1'b0;
    for (int i = 0; i < 2048; i++)
      rnd_coef[i] = ($urandom_range(0, 299) == 0) ? $urandom : 32'($urandom_range(0, 1023));
    rnd_coef[777] = 32'h0001_0155;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(posedge clk); #1;
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;

    run_stream(0, 1'b0, -1, -1);
    run_stream(0, 1'b1, -1, -1);
    run_stream(1, 1'b0, -1, -1);
    repeat (3) @(negedge clk);
    chk("range_err_sticky", 32'(range_err), 32'd1);
    run_stream(0, 1'b0, 101, -1);
    run_stream(0, 1'b0, -1, -1);
    run_stream(2, 1'b0, -1, 500);
    run_stream(3, 1'b1, -1, 7);

    for (int c = 0; (c < 4 * LIMIT) && (sw_fin != 2'b11); c++) @(posedge clk);
    chk("sweep_finish", 32'(sw_fin), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
